// File: rtl/smpl_circ_queue_if.sv
// Sample-stream interface for smpl_circ_queue: write strobe, flush and the
// sequenced window read-out with its framing and status flags.
interface smpl_circ_queue_if #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2
);
  logic                         flush;
  logic                         wrt_smpl;
  logic [CHANNELS*DATA_W-1:0]   new_smpl;
  logic [CHANNELS*DATA_W-1:0]   smpl_out;
  logic                         sequencing;
  logic                         seq_first;
  logic                         seq_last;
  logic                         full;
  logic                         ovr;

  modport master (
    output flush, wrt_smpl, new_smpl,
    input  smpl_out, sequencing, seq_first, seq_last, full, ovr
  );

  modport slave (
    input  flush, wrt_smpl, new_smpl,
    output smpl_out, sequencing, seq_first, seq_last, full, ovr
  );
endinterface

// File: rtl/smpl_circ_queue.sv
// Multi-channel circular sample queue. Keeps the last DEPTH accepted samples
// per channel and, once full, replays the whole window oldest-to-newest after
// every accepted write. Writes never stall; a write that lands during a replay
// queues one follow-up window, and a second such write raises sticky ovr.
module smpl_circ_queue #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 1536,
  parameter int CHANNELS = 2,
  parameter int DECIM    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  smpl_circ_queue_if.slave  bus
);

  localparam int SW = CHANNELS * DATA_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [DW-1:0] DECIM_LAST = DW'(DECIM - 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEQ  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_decim_cnt;
  logic             r_pending;
  logic             r_ovr;
  logic             r_full;
  logic [PW-1:0]    r_rd_addr;
  logic [PW-1:0]    r_rd_idx;
  logic [SW-1:0]    r_mem [DEPTH];
  logic [SW-1:0]    r_smpl_out;
  logic             r_sequencing;
  logic             r_seq_first;
  logic             r_seq_last;

  logic             w_accept;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_addr_nxt;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_rd_en;
  logic             w_win_done;

  // flush wins over a coincident strobe; only decimation slot 0 is stored
  assign w_accept      = bus.wrt_smpl & (r_decim_cnt == {DW{1'b0}}) & ~bus.flush;
  assign w_wr_ptr_nxt  = (r_wr_ptr == LAST_PTR) ? {PW{1'b0}} : r_wr_ptr + PW'(1);
  assign w_rd_addr_nxt = (r_rd_addr == LAST_PTR) ? {PW{1'b0}} : r_rd_addr + PW'(1);
  assign w_cnt_inc     = (r_cnt == FULL_CNT) ? r_cnt : r_cnt + CW'(1);
  assign w_rd_en       = (r_state == ST_SEQ);
  assign w_win_done    = w_rd_en & (r_rd_idx == LAST_PTR);

  // Write pointer, fill count, decimation phase and the full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= {PW{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_decim_cnt <= {DW{1'b0}};
      r_full      <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= {PW{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_decim_cnt <= {DW{1'b0}};
      r_full      <= 1'b0;
    end else begin
      if (bus.wrt_smpl) begin
        r_decim_cnt <= (r_decim_cnt == DECIM_LAST) ? {DW{1'b0}} : r_decim_cnt + DW'(1);
      end
      if (w_accept) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_cnt    <= w_cnt_inc;
        r_full   <= (w_cnt_inc == FULL_CNT);
      end
    end
  end

  // Window sequencer: start/restart windows at the oldest entry, track pending and overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FILL;
      r_rd_addr <= {PW{1'b0}};
      r_rd_idx  <= {PW{1'b0}};
      r_pending <= 1'b0;
      r_ovr     <= 1'b0;
    end else if (bus.flush) begin
      r_state   <= ST_FILL;
      r_rd_addr <= {PW{1'b0}};
      r_rd_idx  <= {PW{1'b0}};
      r_pending <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept && (w_cnt_inc == FULL_CNT)) begin
            r_state   <= ST_SEQ;
            r_rd_addr <= w_wr_ptr_nxt;
            r_rd_idx  <= {PW{1'b0}};
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_SEQ;
            r_rd_addr <= w_wr_ptr_nxt;
            r_rd_idx  <= {PW{1'b0}};
          end
        end
        ST_SEQ: begin
          if (w_accept && r_pending) begin
            r_ovr <= 1'b1;
          end
          if (w_win_done) begin
            if (r_pending || w_accept) begin
              // back-to-back window based on the pointer after this cycle's write
              r_rd_addr <= w_accept ? w_wr_ptr_nxt : r_wr_ptr;
              r_rd_idx  <= {PW{1'b0}};
              r_pending <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_rd_addr <= w_rd_addr_nxt;
            r_rd_idx  <= r_rd_idx + PW'(1);
            if (w_accept) begin
              r_pending <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  // Sample storage; the slot overwritten during a window has already been read
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= bus.new_smpl;
    end
  end

  // Registered read port and window framing, one cycle behind the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smpl_out   <= {SW{1'b0}};
      r_sequencing <= 1'b0;
      r_seq_first  <= 1'b0;
      r_seq_last   <= 1'b0;
    end else if (bus.flush) begin
      r_sequencing <= 1'b0;
      r_seq_first  <= 1'b0;
      r_seq_last   <= 1'b0;
    end else begin
      r_sequencing <= w_rd_en;
      r_seq_first  <= w_rd_en & (r_rd_idx == {PW{1'b0}});
      r_seq_last   <= w_win_done;
      if (w_rd_en) begin
        r_smpl_out <= r_mem[r_rd_addr];
      end
    end
  end

  assign bus.smpl_out   = r_smpl_out;
  assign bus.sequencing = r_sequencing;
  assign bus.seq_first  = r_seq_first;
  assign bus.seq_last   = r_seq_last;
  assign bus.full       = r_full;
  assign bus.ovr        = r_ovr;

endmodule

// File: tb/tb_smpl_circ_queue.sv
// Bench for smpl_circ_queue: two instances (DEPTH=8/DECIM=1 and DEPTH=4/DECIM=3)
// share one stimulus stream; a window-level reference model predicts every
// output cycle by cycle.
module tb_smpl_circ_queue;
  localparam int DATA_W = 16;
  localparam int CH     = 2;
  localparam int SW     = DATA_W * CH;
  localparam int RING   = 32;
  localparam int MAXD   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smpl_circ_queue_if #(.DATA_W(DATA_W), .CHANNELS(CH)) bus_a ();
  smpl_circ_queue_if #(.DATA_W(DATA_W), .CHANNELS(CH)) bus_b ();

  smpl_circ_queue #(.DATA_W(DATA_W), .DEPTH(8), .CHANNELS(CH), .DECIM(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  smpl_circ_queue #(.DATA_W(DATA_W), .DEPTH(4), .CHANNELS(CH), .DECIM(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_err = 0;
  int n_chk = 0;
  int cyc_n = 0;

  // reference model state, index 0 = instance A, 1 = instance B
  int           m_depth [2] = '{8, 4};
  int           m_decim [2] = '{1, 3};
  logic [SW-1:0] m_hist [2][MAXD];
  int           m_hsz   [2];
  int           m_cnt   [2];
  int           m_dcnt  [2];
  bit           m_pend  [2];
  bit           m_ovr   [2];
  int           m_first [2];
  int           m_lastaddr [2];
  logic [SW-1:0] m_out  [2];
  bit           e_v [2][RING];
  bit           e_f [2][RING];
  bit           e_l [2][RING];
  logic [SW-1:0] e_d [2][RING];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic model_flush(input int k);
    m_hsz[k] = 0; m_cnt[k] = 0; m_dcnt[k] = 0;
    m_pend[k] = 1'b0; m_ovr[k] = 1'b0;
    m_first[k] = -1; m_lastaddr[k] = -1;
    for (int s = 0; s < RING; s++) begin
      e_v[k][s] = 1'b0; e_f[k][s] = 1'b0; e_l[k][s] = 1'b0;
    end
  endtask

  task automatic model_reset(input int k);
    model_flush(k);
    m_out[k] = '0;
  endtask

  // window = the last DEPTH accepted samples, emitted at cycles t+2 .. t+DEPTH+1
  task automatic schedule(input int k);
    int s;
    for (int i = 0; i < m_depth[k]; i++) begin
      s = (cyc_n + 2 + i) % RING;
      e_v[k][s] = 1'b1;
      e_d[k][s] = m_hist[k][i];
      e_f[k][s] = (i == 0);
      e_l[k][s] = (i == m_depth[k] - 1);
    end
    m_first[k]    = cyc_n + 1;
    m_lastaddr[k] = cyc_n + m_depth[k];
  endtask

  task automatic model_step(input int k, input bit wr, input bit fl, input logic [SW-1:0] d);
    bit busy;
    bit acc;
    if (fl) begin
      model_flush(k);
      return;
    end
    busy = (cyc_n >= m_first[k]) && (cyc_n <= m_lastaddr[k]);
    acc  = 1'b0;
    if (wr) begin
      acc = (m_dcnt[k] == 0);
      m_dcnt[k] = (m_dcnt[k] + 1) % m_decim[k];
    end
    if (acc) begin
      if (m_hsz[k] < m_depth[k]) begin
        m_hist[k][m_hsz[k]] = d;
        m_hsz[k]++;
      end else begin
        for (int j = 0; j < m_depth[k] - 1; j++) m_hist[k][j] = m_hist[k][j+1];
        m_hist[k][m_depth[k]-1] = d;
      end
      if (m_cnt[k] < m_depth[k]) m_cnt[k]++;
      if (busy) begin
        if (m_pend[k]) m_ovr[k] = 1'b1;
        m_pend[k] = 1'b1;
      end else if (m_cnt[k] == m_depth[k]) begin
        schedule(k);
      end
    end
    if (busy && (cyc_n == m_lastaddr[k]) && m_pend[k]) begin
      schedule(k);
      m_pend[k] = 1'b0;
    end
  endtask

  task automatic check_dut(input int k, input string nm, input logic [SW-1:0] so,
                           input bit sq, input bit sf, input bit sl, input bit fu, input bit ov);
    int s;
    s = cyc_n % RING;
    if (e_v[k][s]) m_out[k] = e_d[k][s];
    check_val({nm, ".sequencing"}, 64'(sq), 64'(e_v[k][s]));
    check_val({nm, ".seq_first"},  64'(sf), 64'(e_v[k][s] & e_f[k][s]));
    check_val({nm, ".seq_last"},   64'(sl), 64'(e_v[k][s] & e_l[k][s]));
    check_val({nm, ".smpl_out"},   64'(so), 64'(m_out[k]));
    check_val({nm, ".full"},       64'(fu), 64'(m_cnt[k] == m_depth[k]));
    check_val({nm, ".ovr"},        64'(ov), 64'(m_ovr[k]));
    e_v[k][s] = 1'b0; e_f[k][s] = 1'b0; e_l[k][s] = 1'b0;
  endtask

  task automatic drive(input bit wr, input bit fl, input logic [SW-1:0] d);
    bus_a.wrt_smpl = wr; bus_a.flush = fl; bus_a.new_smpl = d;
    bus_b.wrt_smpl = wr; bus_b.flush = fl; bus_b.new_smpl = d;
  endtask

  // one clock cycle: check outputs of this cycle, then apply and model its inputs
  task automatic cyc(input bit wr, input bit fl, input logic [SW-1:0] d);
    @(negedge clk);
    check_dut(0, "A", bus_a.smpl_out, bus_a.sequencing, bus_a.seq_first, bus_a.seq_last, bus_a.full, bus_a.ovr);
    check_dut(1, "B", bus_b.smpl_out, bus_b.sequencing, bus_b.seq_first, bus_b.seq_last, bus_b.full, bus_b.ovr);
    drive(wr, fl, d);
    model_step(0, wr, fl, d);
    model_step(1, wr, fl, d);
    cyc_n++;
  endtask

  function automatic logic [SW-1:0] pair(input int v0, input int v1);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(v0);
    b = 16'(v1);
    return {b, a};
  endfunction

  task automatic async_reset_check();
    @(negedge clk);
    drive(1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst.A.smpl_out",   64'(bus_a.smpl_out), 64'd0);
    check_val("rst.A.sequencing", 64'(bus_a.sequencing), 64'd0);
    check_val("rst.A.seq_first",  64'(bus_a.seq_first), 64'd0);
    check_val("rst.A.seq_last",   64'(bus_a.seq_last), 64'd0);
    check_val("rst.A.full",       64'(bus_a.full), 64'd0);
    check_val("rst.A.ovr",        64'(bus_a.ovr), 64'd0);
    check_val("rst.B.smpl_out",   64'(bus_b.smpl_out), 64'd0);
    check_val("rst.B.full",       64'(bus_b.full), 64'd0);
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int p;
    bit wr;
    bit fl;
    drive(1'b0, 1'b0, '0);
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // fill 1..8 (ch1 = k+100), strobes 4 cycles apart
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, pair(k, k + 100));
      repeat (3) cyc(1'b0, 1'b0, '0);
    end
    repeat (8) cyc(1'b0, 1'b0, '0);

    // wrap: samples 9..20, strobes 12 cycles apart
    for (int k = 9; k <= 20; k++) begin
      cyc(1'b1, 1'b0, pair(k, k + 100));
      repeat (11) cyc(1'b0, 1'b0, '0);
    end

    // back-to-back and overrun: three strobes inside one window
    cyc(1'b1, 1'b0, pair(21, 121));
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, pair(22, 122));
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, pair(23, 123));
    repeat (20) cyc(1'b0, 1'b0, '0);

    // asynchronous reset in the middle of a window
    cyc(1'b1, 1'b0, pair(24, 124));
    repeat (3) cyc(1'b0, 1'b0, '0);
    async_reset_check();

    // refill, then flush mid-window, then flush coincident with a strobe
    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, pair(200 + k, 300 + k));
    repeat (3) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, '0);
    repeat (4) cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, pair(77, 77));
    repeat (3) cyc(1'b0, 1'b0, '0);

    // decimation: values 0..11, strobes 2 cycles apart
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b0, pair(k, k + 50));
      cyc(1'b0, 1'b0, '0);
    end
    repeat (12) cyc(1'b0, 1'b0, '0);

    // randomized traffic with varying strobe density and rare flushes
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 3)
        0:       p = 8;
        1:       p = 30;
        default: p = 60;
      endcase
      wr = ($urandom_range(0, 99) < p);
      fl = ($urandom_range(0, 299) == 0);
      cyc(wr, fl, SW'($urandom));
    end
    repeat (20) cyc(1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/smpl_circ_queue.md
Name: smpl_circ_queue

Overview:
Parametrised multi-channel circular sample queue that feeds the FIR filter datapath of the audio equalizer. It stores the last DEPTH accepted samples per channel. Once full, every new accepted sample triggers a burst read of the whole window, oldest to newest. It supersedes the fixed 1536x16 high-frequency queue, adds decimated writes for low-frequency bands, provides multi-channel storage, and makes overrun and flush behaviour explicit. The block runs fully in the clk domain.

Parameters:
DATA_W, 16, bits per channel sample
DEPTH, 1536, samples held per channel; any value >= 4, not required to be a power of 2
CHANNELS, 2, number of parallel channels; all channels share pointers
DECIM, 1, write one of every DECIM wrt_smpl strobes (1 = every strobe); must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of queue state
wrt_smpl  in  1  one-cycle sample strobe, synchronous to clk
new_smpl  in  CHANNELS*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
smpl_out  out  CHANNELS*DATA_W  window sample, same packing as new_smpl
sequencing  out  1  smpl_out is valid this cycle
seq_first  out  1  first (oldest) sample of a window
seq_last  out  1  last (newest) sample of a window
full  out  1  DEPTH samples have been accepted since reset/flush
ovr  out  1  sticky overrun flag; cleared only by reset or flush

Behaviour:
- Reset is rst_n, asynchronous, active-low; the clock is clk. On reset: wr_ptr=0, cnt=0, decim_cnt=0, state=FILL, pending=0. All outputs are 0, including smpl_out.
- Decimation: decim_cnt counts wrt_smpl strobes modulo DECIM. A strobe is accepted when decim_cnt==0, so the first strobe after reset or flush is always accepted.
- Accepted write in cycle T: all channels are written at wr_ptr at the end of T. wr_ptr then advances, wrapping from DEPTH-1 to 0. cnt increments and saturates at DEPTH.
- full = (cnt==DEPTH), registered.
- Storage is synchronous-read memory with 1-cycle read latency. smpl_out holds its last value when sequencing=0.
- FSM states: FILL, IDLE, SEQ.
  - FILL: accepts writes with no reads. The write that makes cnt==DEPTH moves the FSM to SEQ.
  - IDLE: an accepted write moves the FSM to SEQ.
  - SEQ: issues DEPTH read addresses on consecutive cycles. The start address is the post-write wr_ptr, which is the oldest entry. Addresses increment and wrap from DEPTH-1 to 0. The window bounds are latched at entry, so later writes do not alter the window.
- Latency: the triggering write is in cycle T. Read addresses are issued in cycles T+1..T+DEPTH. sequencing is high for cycles T+2..T+DEPTH+1, exactly DEPTH cycles. seq_first is high at T+2 and seq_last is high at T+DEPTH+1.
- Accepted write during SEQ:
  - The sample is always written (audio never stalls). It overwrites the oldest slot, which has already been read.
  - pending is set.
  - If pending is already 1, ovr is set and the extra request merges into the pending one.
- End of SEQ with pending=1: the next window starts with no gap. Its first read address is issued in the cycle after the previous window's last address, so sequencing stays high continuously and seq_first marks the boundary. The new window base is the wr_ptr at restart, and pending clears.
- End of SEQ with pending=0: the FSM returns to IDLE.
- An accepted write in the same cycle as the final SEQ read address counts as pending, so the next window follows back-to-back.
- flush: takes priority over any write in the same cycle. It resets wr_ptr, cnt, decim_cnt, pending, ovr and the FSM to FILL. It aborts any sequence, and sequencing drops on the next cycle. Memory contents are not cleared.
- Asserting rst_n low mid-sequence immediately forces all outputs to 0.
- cnt width is $clog2(DEPTH+1); pointer width is $clog2(DEPTH).

Test Plan:
- Fill: DEPTH=8, CHANNELS=2, DECIM=1. Write samples 1..8 (ch0=k, ch1=k+100), strobes 4 cycles apart → full=1 after the 8th. sequencing is high for 8 cycles starting 2 cycles after the 8th strobe. ch0 outputs 1..8 and ch1 outputs 101..108. seq_first is on sample 1 and seq_last on sample 8.
- Wrap: continue with samples 9..20, strobes 12 cycles apart → each window is the last 8 samples oldest-first, e.g. after sample 20 the window is 13..20. ovr=0 throughout.
- Back-to-back: DEPTH=8, full queue, strobe during SEQ → the second window follows with no sequencing gap and includes the new sample as newest. A third strobe in the same SEQ → ovr=1 and stays 1.
- Decimation: DECIM=3, DEPTH=4, 12 strobes carrying values 0..11 → stored values are 0,3,6,9. full rises on the 10th strobe (value 9). Non-accepted strobes trigger no sequence.
- Flush: flush mid-SEQ → sequencing=0 on the next cycle, full=0, ovr=0. The next DEPTH accepted writes produce no output until the DEPTH-th. A flush coincident with wrt_smpl → the write is ignored (cnt=0).
- Reset: rst_n low mid-SEQ → all outputs are 0 asynchronously. After release the FSM is in FILL and needs DEPTH writes before the first window.
